// File: rtl/ooo_pkg.sv
// ---------------------------------------------------------------------------
// ooo_pkg : shared types and issue-packet layout for the rename stage
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ooo_pkg;

  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;

  localparam int ISSUE_MAPA_LSB  = 0;
  localparam int ISSUE_MAPB_LSB  = 6;
  localparam int ISSUE_MAPWR_LSB = 12;
  localparam int ISSUE_INFO_LSB  = 18;
  localparam int ISSUE_W         = 186;

  typedef logic [5:0] phys_t;
  typedef logic [4:0] arch_t;

  function automatic logic [NUM_PHYS-1:0] phys_bit(input phys_t p);
    return {{(NUM_PHYS-1){1'b0}}, 1'b1} << p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/free_list_penc.sv
// ---------------------------------------------------------------------------
// free_list_penc : lowest-set-bit priority encoder over the free bitmap
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module free_list_penc
  import ooo_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_req,
  output phys_t            o_idx,
  output logic             o_valid
);

  // Scan downwards so the last hit written is the lowest set bit.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = phys_t'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rename_unit.sv
// ---------------------------------------------------------------------------
// rename_unit : register rename with bitmap free list, ready vector and RRAT
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rename_unit
  import ooo_pkg::*;
#(
  parameter int NUM_ARCH = 32,
  parameter int NUM_PHYS = 64,
  parameter int INFO_W   = 168
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             STALL,
  input  logic                             FLUSH,
  input  logic                             dec_valid,
  input  logic [4:0]                       dec_arch_a,
  input  logic [4:0]                       dec_arch_b,
  input  logic [4:0]                       dec_arch_wr,
  input  logic                             dec_wr_en,
  input  logic [INFO_W-1:0]                dec_info,
  output logic                             rename_stall,
  input  logic                             issue_halt,
  input  logic                             exe_broadcast,
  input  logic [5:0]                       exe_broadcast_map,
  input  logic                             rob_commit,
  input  logic [4:0]                       rob_commit_arch,
  input  logic [5:0]                       rob_commit_phys,
  input  logic [5:0]                       rob_commit_old_phys,
  output logic                             rename_enque,
  output logic [31:0]                      rename_instr_num,
  output logic [ISSUE_INFO_LSB+INFO_W-1:0] rename_issueinfo,
  output logic [5:0]                       rename_old_map,
  output logic [NUM_PHYS-1:0]              busy
);

  localparam logic [NUM_PHYS-1:0] c_free_rst = {{(NUM_PHYS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};

  phys_t                             r_spec_rat [NUM_ARCH];
  phys_t                             r_ret_rat  [NUM_ARCH];
  phys_t                             w_ret_rat_nxt [NUM_ARCH];
  logic [NUM_PHYS-1:0]               r_free_map, r_ret_used, r_busy;
  logic [NUM_PHYS-1:0]               w_free_nxt, w_ret_used_nxt, w_busy_nxt;
  logic [31:0]                       r_seq, r_instr_num;
  logic                              r_enque;
  logic [ISSUE_INFO_LSB+INFO_W-1:0]  r_issueinfo, w_pkt;
  phys_t                             r_old_map;
  phys_t                             w_alloc_p, w_map_a, w_map_b, w_map_wr, w_old_wr;
  logic                              w_alloc_valid, w_need_alloc, w_accept, w_do_alloc, w_old_free;

  free_list_penc #(.WIDTH(NUM_PHYS)) u_penc (
    .i_req   (r_free_map),
    .o_idx   (w_alloc_p),
    .o_valid (w_alloc_valid)
  );

  assign w_need_alloc = dec_wr_en & (dec_arch_wr != '0);
  assign rename_stall = STALL | issue_halt | (w_need_alloc & ~w_alloc_valid);
  assign w_accept     = dec_valid & ~rename_stall & ~FLUSH;
  assign w_do_alloc   = w_accept & w_need_alloc;
  assign w_old_free   = rob_commit & (rob_commit_old_phys != '0) &
                        (rob_commit_old_phys != rob_commit_phys);

  assign w_map_a  = r_spec_rat[dec_arch_a];
  assign w_map_b  = r_spec_rat[dec_arch_b];
  assign w_map_wr = w_need_alloc ? w_alloc_p : '0;
  assign w_old_wr = w_need_alloc ? r_spec_rat[dec_arch_wr] : '0;

  always_comb begin
    w_pkt = '0;
    w_pkt[ISSUE_MAPA_LSB  +: $bits(phys_t)] = w_map_a;
    w_pkt[ISSUE_MAPB_LSB  +: $bits(phys_t)] = w_map_b;
    w_pkt[ISSUE_MAPWR_LSB +: $bits(phys_t)] = w_map_wr;
    w_pkt[ISSUE_INFO_LSB  +: INFO_W]        = dec_info;
  end

  // Commit is folded in first so a same-cycle flush restores the post-commit state.
  always_comb begin
    w_ret_rat_nxt  = r_ret_rat;
    w_ret_used_nxt = r_ret_used;
    w_free_nxt     = r_free_map;
    w_busy_nxt     = r_busy;
    if (rob_commit) begin
      w_ret_rat_nxt[rob_commit_arch] = rob_commit_phys;
      w_ret_used_nxt = (r_ret_used & ~phys_bit(rob_commit_old_phys)) | phys_bit(rob_commit_phys);
    end
    if (w_old_free) w_free_nxt = w_free_nxt | phys_bit(rob_commit_old_phys);
    if (w_do_alloc) w_free_nxt = w_free_nxt & ~phys_bit(w_alloc_p);
    if (exe_broadcast && exe_broadcast_map != '0)
      w_busy_nxt = w_busy_nxt | phys_bit(exe_broadcast_map);
    if (w_do_alloc) w_busy_nxt = w_busy_nxt & ~phys_bit(w_alloc_p);
    if (FLUSH) begin
      w_free_nxt = ~w_ret_used_nxt & ~phys_bit('0);
      w_busy_nxt = '1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        r_spec_rat[i] <= phys_t'(i);
        r_ret_rat[i]  <= phys_t'(i);
      end
      r_free_map  <= c_free_rst;
      r_ret_used  <= ~c_free_rst;
      r_busy      <= '1;
      r_seq       <= '0;
      r_enque     <= 1'b0;
      r_instr_num <= '0;
      r_issueinfo <= '0;
      r_old_map   <= '0;
    end else begin
      r_ret_rat  <= w_ret_rat_nxt;
      r_ret_used <= w_ret_used_nxt;
      r_free_map <= w_free_nxt;
      r_busy     <= w_busy_nxt;
      r_enque    <= w_accept;
      if (FLUSH) begin
        r_spec_rat <= w_ret_rat_nxt;
      end else if (w_do_alloc) begin
        r_spec_rat[dec_arch_wr] <= w_alloc_p;
      end
      if (w_accept) begin
        r_seq       <= r_seq + 32'd1;
        r_instr_num <= r_seq;
        r_issueinfo <= w_pkt;
        r_old_map   <= w_old_wr;
      end
    end
  end

  assign rename_enque     = r_enque;
  assign rename_instr_num = r_instr_num;
  assign rename_issueinfo = r_issueinfo;
  assign rename_old_map   = r_old_map;
  assign busy             = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rename_unit.sv
// ---------------------------------------------------------------------------
// tb_rename_unit : self-checking bench for rename_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rename_unit;
  import ooo_pkg::*;

  logic         CLK = 1'b0;
  logic         RESET, STALL, FLUSH, dec_valid, dec_wr_en, issue_halt;
  logic [4:0]   dec_arch_a, dec_arch_b, dec_arch_wr, rob_commit_arch;
  logic [167:0] dec_info;
  logic         rename_stall, exe_broadcast, rob_commit, rename_enque;
  logic [5:0]   exe_broadcast_map, rob_commit_phys, rob_commit_old_phys, rename_old_map;
  logic [31:0]  rename_instr_num;
  logic [185:0] rename_issueinfo;
  logic [63:0]  busy;

  rename_unit #(.NUM_ARCH(32), .NUM_PHYS(64), .INFO_W(168)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .dec_valid(dec_valid), .dec_arch_a(dec_arch_a), .dec_arch_b(dec_arch_b),
    .dec_arch_wr(dec_arch_wr), .dec_wr_en(dec_wr_en), .dec_info(dec_info),
    .rename_stall(rename_stall), .issue_halt(issue_halt),
    .exe_broadcast(exe_broadcast), .exe_broadcast_map(exe_broadcast_map),
    .rob_commit(rob_commit), .rob_commit_arch(rob_commit_arch),
    .rob_commit_phys(rob_commit_phys), .rob_commit_old_phys(rob_commit_old_phys),
    .rename_enque(rename_enque), .rename_instr_num(rename_instr_num),
    .rename_issueinfo(rename_issueinfo), .rename_old_map(rename_old_map), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [185:0] pkt;
    logic [5:0]   old;
    logic [31:0]  num;
  } exp_t;

  typedef struct {
    arch_t a, b, wr;
    logic  en;
    phys_t ea, eb, ewr, eold;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[7];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_seq = 0;
  logic [63:0] exp_busy;
  phys_t       prev;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int wr, input int en,
                              input int ea, input int eb, input int ew, input int eo);
    vec_t v;
    v.a = arch_t'(a); v.b = arch_t'(b); v.wr = arch_t'(wr); v.en = en[0];
    v.ea = phys_t'(ea); v.eb = phys_t'(eb); v.ewr = phys_t'(ew); v.eold = phys_t'(eo);
    return v;
  endfunction

  // Drive one instruction; when acceptance is expected, queue its packet.
  task automatic issue(input int a, input int b, input int wr, input int en, input bit accept,
                       input int ea, input int eb, input int ew, input int eo);
    exp_t e;
    dec_valid   = 1'b1;
    dec_arch_a  = arch_t'(a);
    dec_arch_b  = arch_t'(b);
    dec_arch_wr = arch_t'(wr);
    dec_wr_en   = en[0];
    dec_info    = 168'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    if (accept) begin
      e.pkt = {dec_info, phys_t'(ew), phys_t'(eb), phys_t'(ea)};
      e.old = phys_t'(eo);
      e.num = exp_seq;
      exp_seq++;
      sb.push_back(e);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET && rename_enque) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_enque: got 1 expected 0 (instr_num %0d)", rename_instr_num);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pkt", 192'(rename_issueinfo), 192'(e.pkt));
        check("old_map", 192'(rename_old_map), 192'(e.old));
        check("instr_num", 192'(rename_instr_num), 192'(e.num));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(1, 2, 3, 1,   1,  2, 32, 3);
    vecs[1] = mk(3, 0, 4, 1,  32,  0, 33, 4);
    vecs[2] = mk(4, 0, 5, 1,  33,  0, 34, 5);
    vecs[3] = mk(1, 1, 1, 1,   1,  1, 35, 1);
    vecs[4] = mk(5, 0, 0, 1,  34,  0,  0, 0);
    vecs[5] = mk(3, 4, 6, 0,  32, 33,  0, 0);
    vecs[6] = mk(5, 2, 6, 1,  34,  2, 36, 6);

    RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0; dec_valid = 1'b0; dec_wr_en = 1'b0;
    issue_halt = 1'b0; dec_arch_a = '0; dec_arch_b = '0; dec_arch_wr = '0; dec_info = '0;
    exe_broadcast = 1'b0; exe_broadcast_map = '0; rob_commit = 1'b0;
    rob_commit_arch = '0; rob_commit_phys = '0; rob_commit_old_phys = '0;
    repeat (2) @(negedge CLK);
    check("rst_enque", 192'(rename_enque), 192'(0));
    check("rst_num", 192'(rename_instr_num), 192'(0));
    check("rst_pkt", 192'(rename_issueinfo), 192'(0));
    check("rst_old", 192'(rename_old_map), 192'(0));
    check("rst_busy", 192'(busy), 192'({64{1'b1}}));
    RESET = 1'b1;

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].wr, vecs[i].en, 1'b1,
            vecs[i].ea, vecs[i].eb, vecs[i].ewr, vecs[i].eold);
      @(negedge CLK);
    end
    dec_valid = 1'b0;
    @(negedge CLK);
    exp_busy = '1;
    for (int k = 32; k <= 36; k++) exp_busy[k] = 1'b0;
    check("busy_after_alloc", 192'(busy), 192'(exp_busy));

    exe_broadcast = 1'b1; exe_broadcast_map = 6'd32;
    @(negedge CLK);
    exe_broadcast = 1'b0;
    exp_busy[32] = 1'b1;
    check("busy_bcast32", 192'(busy), 192'(exp_busy));

    // Drain the remaining 27 free registers through r10.
    prev = 6'd10;
    for (int k = 0; k < 27; k++) begin
      issue(10, 0, 10, 1, 1'b1, prev, 0, 37 + k, prev);
      prev = phys_t'(37 + k);
      @(negedge CLK);
    end
    issue(0, 0, 11, 1, 1'b0, 0, 0, 0, 0);
    #1 check("stall_empty", 192'(rename_stall), 192'(1));
    @(negedge CLK);
    check("enque_empty", 192'(rename_enque), 192'(0));
    issue(0, 0, 11, 0, 1'b1, 0, 0, 0, 0);
    #1 check("nowrite_no_stall", 192'(rename_stall), 192'(0));
    @(negedge CLK);
    issue(0, 0, 11, 1, 1'b0, 0, 0, 0, 0);
    rob_commit = 1'b1; rob_commit_arch = 5'd7; rob_commit_phys = 6'd37; rob_commit_old_phys = 6'd7;
    #1 check("stall_commit_cycle", 192'(rename_stall), 192'(1));
    @(negedge CLK);
    rob_commit = 1'b0;
    check("enque_commit_cycle", 192'(rename_enque), 192'(0));
    #1 check("stall_after_free", 192'(rename_stall), 192'(0));
    sb.push_back('{pkt: {dec_info, 6'd7, 6'd0, 6'd0}, old: 6'd11, num: exp_seq});
    exp_seq++;
    @(negedge CLK);

    // Stall: no acceptance, but broadcast still lands.
    issue(0, 0, 12, 0, 1'b0, 0, 0, 0, 0);
    STALL = 1'b1; exe_broadcast = 1'b1; exe_broadcast_map = 6'd33;
    #1 check("stall_out", 192'(rename_stall), 192'(1));
    @(negedge CLK);
    exe_broadcast = 1'b0;
    check("enque_stall", 192'(rename_enque), 192'(0));
    check("busy33_stall", 192'(busy[33]), 192'(1));

    issue_halt = 1'b1;
    #3 RESET = 1'b0;
    #1;
    check("arst_busy", 192'(busy), 192'({64{1'b1}}));
    check("arst_num", 192'(rename_instr_num), 192'(0));
    check("arst_pkt", 192'(rename_issueinfo), 192'(0));
    check("arst_old", 192'(rename_old_map), 192'(0));
    @(negedge CLK);
    RESET = 1'b1; STALL = 1'b0; issue_halt = 1'b0; dec_valid = 1'b0;
    exp_seq = 0;
    @(negedge CLK);

    issue(0, 0, 1, 1, 1'b1, 0, 0, 32, 1);
    @(negedge CLK);
    issue(0, 0, 2, 1, 1'b1, 0, 0, 33, 2);
    @(negedge CLK);
    issue(0, 0, 5, 1, 1'b0, 0, 0, 0, 0);
    FLUSH = 1'b1;
    rob_commit = 1'b1; rob_commit_arch = 5'd1; rob_commit_phys = 6'd32; rob_commit_old_phys = 6'd1;
    @(negedge CLK);
    FLUSH = 1'b0; rob_commit = 1'b0; dec_valid = 1'b0;
    check("enque_flush", 192'(rename_enque), 192'(0));
    check("busy_flush", 192'(busy), 192'({64{1'b1}}));
    issue(2, 1, 3, 1, 1'b1, 2, 32, 1, 3);
    @(negedge CLK);
    issue(3, 0, 4, 1, 1'b1, 1, 0, 33, 4);
    @(negedge CLK);
    dec_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("sb_empty", 192'(sb.size()), 192'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
